// File: rtl/status_pkg.sv
// Shared constants and types for the status flag register and its save stack.
package status_pkg;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   localparam int unsigned DEF_FLAG_COUNT  = 4;
   localparam int unsigned DEF_STACK_DEPTH = 4;

   typedef enum logic [1:0] {
      LIFO_NONE,
      LIFO_PUSH,
      LIFO_POP,
      LIFO_XCHG
   } lifo_op_t;

endpackage

// File: rtl/flag_lifo.sv
// Snapshot storage for saved flags: push, pop and in-place exchange of the top entry.
module flag_lifo
   import status_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_FLAG_COUNT,
   parameter int unsigned DEPTH = DEF_STACK_DEPTH
) (
   input  logic                       clock,
   input  logic                       status_reset,
   input  lifo_op_t                   op,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;
   logic             has_room;
   logic             has_data;

   always_comb begin
      top_idx  = AW'(count - 1'b1);
      wr_idx   = count[AW-1:0];
      has_room = (count < CW'(DEPTH));
      has_data = (count != '0);
      rd_data  = mem[top_idx];
   end

   // Entries are deliberately left out of reset; only the pointer forgets them.
   always_ff @(posedge clock) begin
      case (op)
         LIFO_PUSH: if (has_room) mem[wr_idx]  <= wr_data;
         LIFO_XCHG: if (has_data) mem[top_idx] <= wr_data;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge status_reset) begin
      if (status_reset) begin
         count <= '0;
      end else begin
         case (op)
            LIFO_PUSH: if (has_room) count <= count + 1'b1;
            LIFO_POP:  if (has_data) count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/status_stack.sv
// Live status flags with masked writes, a save/restore stack and sticky stack error flags.
module status_stack
   import status_pkg::*;
#(
   parameter int unsigned FLAG_COUNT  = DEF_FLAG_COUNT,
   parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
   input  logic                             clock,
   input  logic                             status_reset,
   input  logic [FLAG_COUNT-1:0]            flags_in,
   input  logic [FLAG_COUNT-1:0]            flag_wr_mask,
   input  logic                             status_wr,
   input  logic                             push,
   input  logic                             pop,
   input  logic                             err_clear,
   output logic [FLAG_COUNT-1:0]            flags_out,
   output logic [$clog2(STACK_DEPTH+1)-1:0] depth_count,
   output logic                             stack_full,
   output logic                             stack_empty,
   output logic                             stack_overflow,
   output logic                             stack_underflow
);

   localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

   lifo_op_t              op;
   logic [FLAG_COUNT-1:0] top_data;
   logic [FLAG_COUNT-1:0] next_flags;
   logic                  apply_wr;
   logic                  load_top;
   logic                  ovf_event;
   logic                  unf_event;

   flag_lifo #(
      .WIDTH (FLAG_COUNT),
      .DEPTH (STACK_DEPTH)
   ) u_lifo (
      .clock        (clock),
      .status_reset (status_reset),
      .op           (op),
      .wr_data      (flags_out),
      .rd_data      (top_data),
      .count        (depth_count)
   );

   always_comb begin
      stack_full  = (depth_count == CW'(STACK_DEPTH));
      stack_empty = (depth_count == '0);
   end

   // Any command that restores from the stack discards the masked write;
   // rejected commands (overflow/underflow) leave the write in effect.
   always_comb begin
      op        = LIFO_NONE;
      apply_wr  = status_wr;
      load_top  = 1'b0;
      ovf_event = 1'b0;
      unf_event = 1'b0;
      if (push && pop) begin
         if (stack_empty) begin
            unf_event = 1'b1;
         end else begin
            op       = LIFO_XCHG;
            load_top = 1'b1;
            apply_wr = 1'b0;
         end
      end else if (push) begin
         if (stack_full) ovf_event = 1'b1;
         else            op        = LIFO_PUSH;
      end else if (pop) begin
         if (stack_empty) begin
            unf_event = 1'b1;
         end else begin
            op       = LIFO_POP;
            load_top = 1'b1;
            apply_wr = 1'b0;
         end
      end

      if (load_top)      next_flags = top_data;
      else if (apply_wr) next_flags = (flags_out & ~flag_wr_mask) | (flags_in & flag_wr_mask);
      else               next_flags = flags_out;
   end

   always_ff @(posedge clock or posedge status_reset) begin
      if (status_reset) begin
         flags_out       <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         flags_out       <= next_flags;
         stack_overflow  <= ovf_event | (stack_overflow  & ~err_clear);
         stack_underflow <= unf_event | (stack_underflow & ~err_clear);
      end
   end

endmodule

// File: doc/status_stack.md
STATUS_STACK -- requirements
Module: status_stack

Interface
REQ-001 Parameter FLAG_COUNT, default 4, number of status flags held (bit 0 Z, bit 1 N, bit 2 C, bit 3 V).
REQ-002 Parameter STACK_DEPTH, default 4, number of flag snapshots the save stack holds; legal range 2..16.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 status_reset  input  1  reset, asynchronous, active-high.
REQ-005 flags_in  input  FLAG_COUNT  new flag values from the ALU.
REQ-006 flag_wr_mask  input  FLAG_COUNT  per-flag write enable; it is qualified by status_wr.
REQ-007 status_wr  input  1  commits the masked flags_in bits to the live flags.
REQ-008 push  input  1  saves the live flags onto the stack.
REQ-009 pop  input  1  restores the live flags from the top of the stack.
REQ-010 err_clear  input  1  clears the sticky error flags.
REQ-011 flags_out  output  FLAG_COUNT  live flag register.
REQ-012 depth_count  output  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
REQ-013 stack_full, stack_empty  output  1 each  combinational decode of depth_count (full = STACK_DEPTH, empty = 0).
REQ-014 stack_overflow, stack_underflow  output  1 each  sticky error flags.

Function
REQ-015 All state SHALL update only on the rising clock edge; flags_out SHALL have 1-cycle latency from any command.
REQ-016 status_wr alone: each flags_out[i] with flag_wr_mask[i]=1 SHALL take flags_in[i]; unmasked bits hold.
REQ-017 push alone, not full: the stack SHALL store the pre-edge flags_out at index depth_count; depth_count increments; flags_out is unchanged.
REQ-018 pop alone, not empty: flags_out SHALL load the entry at depth_count-1; depth_count decrements.
REQ-019 push and status_wr together: the stack SHALL save the pre-edge flags_out, and the masked write SHALL apply to flags_out in the same cycle.
REQ-020 pop and status_wr together: pop SHALL win; the masked write is discarded.
REQ-021 push and pop together, not empty: the top entry SHALL be exchanged with flags_out, depth_count is unchanged, and status_wr is discarded.
REQ-022 push and pop together when empty: stack_underflow SHALL be set; no stack change; status_wr still applies.
REQ-023 push when full: stack_overflow SHALL be set; stack and depth_count are unchanged; status_wr still applies.
REQ-024 pop when empty: stack_underflow SHALL be set; flags_out and depth_count are unchanged; status_wr still applies.
REQ-025 Sticky errors SHALL remain set until err_clear=1 at a clock edge; an error event in the same cycle as err_clear SHALL leave the flag set (set wins).
REQ-026 depth_count SHALL never exceed STACK_DEPTH nor wrap below 0.
REQ-027 Stack entries SHALL NOT be readable except through pop or exchange; their contents are not cleared by reset.

Reset
REQ-028 While status_reset=1, flags_out SHALL be 0, depth_count 0, stack_empty 1, stack_full 0, and stack_overflow and stack_underflow 0.
REQ-029 Reset asserted mid-sequence SHALL abandon all stacked snapshots; the first pop after reset SHALL report underflow.

Structure
REQ-030 Package status_pkg SHALL hold the flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3 and the default FLAG_COUNT and STACK_DEPTH values.
REQ-031 Snapshot storage and the pointer SHALL live in one sub-module, flag_lifo (write/read/exchange ports, count output).
REQ-032 status_stack SHALL contain the live register, the command priority decode and the sticky error logic.

Verification
REQ-033 Reset, then status_wr=1, mask=4'b0011, flags_in=4'b1111 -> flags_out=4'b0011 next cycle.
REQ-034 Live flags 4'b0101; push; write 4'b1010 with full mask; pop -> flags_out 4'b1010, then 4'b0101; depth_count 1 then 0.
REQ-035 Push 5 times with STACK_DEPTH=4 -> stack_full after the 4th push; overflow set on the 5th; depth_count stays 4; err_clear -> overflow 0.
REQ-036 Pop on an empty stack together with status_wr of 4'b1000 -> underflow 1, flags_out=4'b1000, depth_count 0.
REQ-037 Live flags 4'b0001, top entry 4'b0110; push and pop together -> flags_out 4'b0110, new top 4'b0001, depth unchanged.
REQ-038 Push 3 entries, assert status_reset asynchronously mid-cycle -> outputs 0 immediately; a following pop -> underflow 1.
